// File: rtl/mem_seq_pkg.sv
// -----------------------------------------------------------------------------
// mem_seq_pkg
// Shared definitions for the emulation-memory bus master (mem_seq) and the
// memory-space slave: request opcodes, sequencer state encoding, region bases
// of the 0xffff8000-0xffffffff emulation space, and small address helpers.
// -----------------------------------------------------------------------------
package mem_seq_pkg;

    // Request opcodes; the reserved code behaves as a read.
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_CP_RD = 3'd3,
        ST_CP_WR = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Region bases of the emulation memory space.
    localparam logic [31:0] CSR_BASE = 32'hffff8000;
    localparam logic [31:0] GPR_BASE = 32'hffffc000;
    localparam logic [31:0] TMP_BASE = 32'hffffc080;
    localparam logic [31:0] CON_BASE = 32'hffffc100;
    localparam logic [31:0] RZ_ADDR  = 32'hffffc200;
    localparam logic [31:0] PRC_BASE = 32'hffffd000;

    localparam logic [31:0] WORD_STEP = 32'd4;

    // Byte address -> word address (bits [1:0] cleared).
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // Inclusive range test on word addresses.
    function automatic logic in_region(input logic [31:0] a,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/mem_seq.sv
// -----------------------------------------------------------------------------
// mem_seq
// Upstream bus master for the emulation memory space. Accepts single reads,
// single writes and block copies over a valid/ready request channel, sequences
// them onto the shared bus (mem_we / mem_addr / tri-state mem_data), and
// returns one response per request over a valid/ready response channel.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_op               00 read, 01 write, 10 copy, 11 read
//   req_addr             read/write address or copy source
//   req_dst, req_len     copy destination and word count
//   req_wdata            write data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (last copied word for a copy)
//   rsp_err              a write of this operation hit the protected region
//   busy                 sequencer not idle
//   mem_we, mem_addr     bus write strobe and word address
//   mem_data             shared bus data, driven only while mem_we=1
//
// Build option: define MEM_SEQ_WPROT_EN to suppress writes into
// RO_START..RO_END and report them on rsp_err. Without it every write is
// issued and rsp_err is always 0.
// -----------------------------------------------------------------------------
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int          LEN_W    = 8,
    parameter logic [31:0] RO_START = 32'hffffc100,
    parameter logic [31:0] RO_END   = 32'hffffc1fc
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_dst,
    input  logic [LEN_W-1:0] req_len,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             busy,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    inout  wire logic [31:0] mem_data
);

`ifdef MEM_SEQ_WPROT_EN
    localparam logic WPROT_EN = 1'b1;
`else
    localparam logic WPROT_EN = 1'b0;
`endif

    state_e state_q, state_d;

    logic [31:0]      addr_q;       // read/write address, copy source
    logic [31:0]      dst_q;        // copy destination
    logic [LEN_W-1:0] cnt_q;        // copy words remaining
    logic [31:0]      data_q;       // write data, or the word in flight of a copy
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [31:0]      last_addr_q;  // bus address held between bus cycles

    logic bus_write;
    logic wr_blocked;
    logic accept;

    assign accept = req_valid && req_ready;

    // ---------------------------------------------------------------- state reg
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge value of every other register, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // --------------------------------------------------------------- next state
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (req_op)
                        OP_WRITE: state_d = ST_WR;
                        OP_COPY:  state_d = (req_len != '0) ? ST_CP_RD : ST_RESP;
                        default:  state_d = ST_RD;   // OP_READ and OP_RSVD
                    endcase
                end
            end
            ST_RD:    state_d = ST_RESP;
            ST_WR:    state_d = ST_RESP;
            ST_CP_RD: state_d = ST_CP_WR;
            ST_CP_WR: state_d = (cnt_q == LEN_W'(1)) ? ST_RESP : ST_CP_RD;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        bus_write = 1'b0;
        mem_addr  = last_addr_q;
        unique case (state_q)
            // Reset holds the FSM in IDLE; gating with rst keeps the request
            // channel closed until reset is released.
            ST_IDLE:  req_ready = rst;
            ST_RD:    mem_addr  = addr_q;
            ST_CP_RD: mem_addr  = addr_q;
            ST_WR: begin
                mem_addr  = addr_q;
                bus_write = 1'b1;
            end
            ST_CP_WR: begin
                mem_addr  = dst_q;
                bus_write = 1'b1;
            end
            ST_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign wr_blocked = WPROT_EN && bus_write && in_region(mem_addr, RO_START, RO_END);
    assign mem_we     = bus_write && !wr_blocked;
    assign mem_data   = mem_we ? data_q : 'z;
    assign busy       = (state_q != ST_IDLE);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = WPROT_EN ? err_q : 1'b0;

    // ----------------------------------------------------------------- datapath
    // NOTE: every datapath register is reset because the reset values are
    // visible on the outputs (mem_addr, rsp_rdata, rsp_err); plain storage with
    // no observable reset value could be left unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            last_addr_q <= '0;
        end else begin
            last_addr_q <= mem_addr;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q <= word_addr(req_addr);
                        dst_q  <= word_addr(req_dst);
                        cnt_q  <= req_len;
                        data_q <= req_wdata;
                        err_q  <= 1'b0;
                    end
                end
                ST_RD: rdata_q <= mem_data;
                ST_CP_RD: begin
                    data_q  <= mem_data;
                    rdata_q <= mem_data;
                end
                ST_WR: if (wr_blocked) err_q <= 1'b1;
                ST_CP_WR: begin
                    // Copies run strictly word-ascending; overlap is not guarded.
                    addr_q <= addr_q + WORD_STEP;
                    dst_q  <= dst_q + WORD_STEP;
                    cnt_q  <= cnt_q - LEN_W'(1);
                    if (wr_blocked) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
module tb_mem_seq;

    localparam int          LEN_W    = 8;
    localparam logic [31:0] RO_START = 32'hffffc100;
    localparam logic [31:0] RO_END   = 32'hffffc1fc;
`ifdef MEM_SEQ_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [31:0]      req_addr = '0;
    logic [31:0]      req_dst = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic [31:0]      req_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             busy;
    logic             mem_we;
    logic [31:0]      mem_addr;
    wire  [31:0]      mem_data;

    always #5 clk = ~clk;

    mem_seq #(.LEN_W(LEN_W), .RO_START(RO_START), .RO_END(RO_END)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_dst(req_dst), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // Bus slave: 8K words covering the emulation space (address bits [14:2]).
    logic [31:0] bus_mem [0:8191];
    logic [31:0] ref_mem [0:8191];
    logic        slave_on = 1'b1;

    assign mem_data = (slave_on && busy && !rsp_valid && !mem_we) ? bus_mem[mem_addr[14:2]] : 32'hz;

    logic [32:0] trace_q[$];
    logic [32:0] exp_trace[$];

    always @(posedge clk) begin
        if (mem_we) bus_mem[mem_addr[14:2]] <= mem_data;
        if (busy && !rsp_valid) trace_q.push_back({mem_we, mem_addr});
    end

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_rdata = '0;
    logic        exp_err;
    int          exp_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[14:2]);
    endfunction

    function automatic bit in_ro(input logic [31:0] a);
        return WPROT && (a >= RO_START) && (a <= RO_END);
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        bus_mem[idx(a)] <= v;
        ref_mem[idx(a)] = v;
    endtask

    // Reference: each operation as a sequence of word reads/writes.
    task automatic model_op(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] dst,
                            input logic [7:0] len, input logic [31:0] wdata);
        logic [31:0] a, d, v;
        logic blk;
        a = {addr[31:2], 2'b00};
        d = {dst[31:2], 2'b00};
        exp_trace.delete();
        exp_err = 1'b0;
        case (op)
            2'b01: begin
                blk = in_ro(a);
                exp_trace.push_back({~blk, a});
                if (!blk) ref_mem[idx(a)] = wdata;
                exp_err = blk;
                exp_lat = 2;
            end
            2'b10: begin
                exp_lat = (len == 0) ? 1 : 2 * int'(len) + 1;
                for (int i = 0; i < int'(len); i++) begin
                    v = ref_mem[idx(a)];
                    last_rdata = v;
                    exp_trace.push_back({1'b0, a});
                    blk = in_ro(d);
                    exp_trace.push_back({~blk, d});
                    if (!blk) ref_mem[idx(d)] = v;
                    if (blk) exp_err = 1'b1;
                    a = a + 32'd4;
                    d = d + 32'd4;
                end
            end
            default: begin
                exp_trace.push_back({1'b0, a});
                last_rdata = ref_mem[idx(a)];
                exp_lat = 2;
            end
        endcase
    endtask

    task automatic check_mem(input string name);
        int mism = 0;
        for (int i = 0; i < 8192; i++) if (bus_mem[i] !== ref_mem[i]) mism++;
        check(name, mism, 0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] dst,
                          input logic [7:0] len, input logic [31:0] wdata, input int hold,
                          output int lat, output logic [31:0] rd);
        logic [31:0] addr_before;
        int n;
        model_op(op, addr, dst, len, wdata);
        addr_before = mem_addr;
        trace_q.delete();
        req_op = op; req_addr = addr; req_dst = dst; req_len = len; req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        check("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 600) begin tick(); lat++; end
        check("latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, last_rdata);
        check("rsp_err", rsp_err, exp_err);
        check("req_ready_resp", req_ready, 0);
        if (op == 2'b10 && len == 0) check("len0_addr", mem_addr, addr_before);
        rd = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, last_rdata);
            check("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("busy_idle", busy, 0);
        check("trace_len", trace_q.size(), exp_trace.size());
        for (int i = 0; i < exp_trace.size() && i < trace_q.size(); i++)
            check($sformatf("trace[%0d]", i), trace_q[i], exp_trace[i]);
        check_mem("mem_image");
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] dst;
        logic [7:0]  len;
        logic [31:0] wdata;
        int          hold;
        int          exp_lat;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd, v, src, dst, addr;
        logic [1:0]  op;
        logic [7:0]  len;
        int          w;

        for (int i = 0; i < 8192; i++) begin
            v = $urandom;
            bus_mem[i] <= v;
            ref_mem[i] = v;
        end

        // Reset values
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 check("rst_hold_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_release_ready", req_ready, 1);

        poke(32'hffffc004, 32'h00000011);
        poke(32'hffffc008, 32'h00000022);
        poke(32'hffffc00c, 32'h00000033);
        poke(32'hffffc104, 32'h00000002);
        poke(32'hffff900c, 32'hc0de900c);

        vecs[0] = '{"rd_const",   2'b00, 32'hffffc104, 32'h0,        8'd0, 32'h0,        0, 2, 1, 32'h00000002};
        vecs[1] = '{"wr",         2'b01, 32'hffffc008, 32'h0,        8'd0, 32'hdeadbeef, 1, 2, 0, 32'h0};
        vecs[2] = '{"rd_back",    2'b00, 32'hffffc008, 32'h0,        8'd0, 32'h0,        0, 2, 1, 32'hdeadbeef};
        vecs[3] = '{"cp3",        2'b10, 32'hffffc004, 32'hffff8000, 8'd3, 32'h0,        0, 7, 1, 32'h00000033};
        vecs[4] = '{"rd_copied",  2'b00, 32'hffff8004, 32'h0,        8'd0, 32'h0,        0, 2, 1, 32'hdeadbeef};
        vecs[5] = '{"rsvd_unal",  2'b11, 32'hffffc106, 32'h0,        8'd0, 32'h0,        2, 2, 1, 32'h00000002};
        vecs[6] = '{"wr_ro",      2'b01, 32'hffffc110, 32'h0,        8'd0, 32'h55aa55aa, 0, 2, 0, 32'h0};
        vecs[7] = '{"cp_span_ro", 2'b10, 32'hffff9000, 32'hffffc0f8, 8'd4, 32'h0,        0, 9, 1, 32'hc0de900c};
        vecs[8] = '{"cp_wrap",    2'b10, 32'hfffffff8, 32'hffff8100, 8'd3, 32'h0,        0, 7, 1, 32'h00000011};
        vecs[9] = '{"cp_len0",    2'b10, 32'hffffc004, 32'hffff8000, 8'd0, 32'h0,        5, 1, 1, 32'h00000011};

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].dst, vecs[i].len, vecs[i].wdata,
                   vecs[i].hold, lat, rd);
            check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            if (vecs[i].chk_rd) check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
        end

        // Reset during the write of word 2 of a 4-word copy
        src = 32'hffffa000;
        dst = 32'hffffb000;
        for (int i = 0; i < 4; i++) begin
            poke(src + 32'(i * 4), 32'ha0000000 + 32'(i));
            poke(dst + 32'(i * 4), 32'h0);
        end
        req_op = 2'b10; req_addr = src; req_dst = dst; req_len = 8'd4;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check("abort_we_before", mem_we, 1);
        check("abort_addr_before", mem_addr, dst + 32'd4);
        #2 rst = 1'b0;
        #1;
        check("abort_mem_we", mem_we, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_mem_addr", mem_addr, 0);
        repeat (2) begin
            tick();
            check("abort_no_rsp", rsp_valid, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready_after", req_ready, 1);
        check("abort_rdata_cleared", rsp_rdata, 0);
        ref_mem[idx(dst)] = ref_mem[idx(src)];
        last_rdata = '0;
        check_mem("abort_partial_mem");

        // Randomized operations against the reference
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            w = (k % 4 == 0) ? int'($urandom_range(32'h1030, 32'h1090)) : int'($urandom_range(0, 8191));
            addr = 32'hffff8000 + 32'(w) * 32'd4 + 32'($urandom_range(0, 3));
            len = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0)
                dst = addr + 32'($urandom_range(0, 3)) * 32'd4;
            else if ($urandom_range(0, 2) == 0)
                dst = 32'hffffc0f0 + 32'($urandom_range(0, 8)) * 32'd4;
            else
                dst = 32'hffff8000 + 32'($urandom_range(0, 8191)) * 32'd4;
            run_op(op, addr, dst, len, $urandom, int'($urandom_range(0, 3)), lat, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
